// File: rtl/mux_nx1_scan_if.sv
// Channel bus for mux_nx1_scan: packed channel inputs and controls toward the mux,
// registered selection result back toward the consumer.
interface mux_nx1_scan_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2
);
  logic [CH*WIDTH-1:0] D;
  logic [SELW-1:0]     SEL;
  logic                Gbar;
  logic                MODE;
  logic [WIDTH-1:0]    Y;
  logic [SELW-1:0]     CH_OUT;
  logic                VALID;
  logic                WRAP;

  modport master (
    output D, SEL, Gbar, MODE,
    input  Y, CH_OUT, VALID, WRAP
  );

  modport slave (
    input  D, SEL, Gbar, MODE,
    output Y, CH_OUT, VALID, WRAP
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// N-channel registered mux with active-low enable and a dwell-timed auto-scan mode
// that steps through every channel and pulses WRAP on the last sample of a frame.
module mux_nx1_scan #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned DWELL = 3
) (
  input  logic          CLK,
  input  logic          RST,
  mux_nx1_scan_if.slave bus
);
  localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  // One extra bit so CH == 2**SELW still compares correctly.
  localparam logic [SELW:0]   ChLim   = (SELW+1)'(CH);
  localparam logic [SELW-1:0] LastCh  = SELW'(CH - 1);
  localparam logic [DCW-1:0]  LastCnt = DCW'(DWELL - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;

  logic             sel_ok;
  logic [SELW-1:0]  src;
  logic [WIDTH-1:0] src_data;

  always_comb begin
    sel_ok   = ({1'b0, bus.SEL} < ChLim);
    src      = bus.MODE ? ptr_q : bus.SEL;
    src_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (src == SELW'(i)) src_data = bus.D[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    if (!bus.Gbar) begin
      if (!bus.MODE) begin
        // Manual select also seeds the scan pointer so a later scan starts here.
        ch_d   = bus.SEL;
        dcnt_d = '0;
        if (sel_ok) begin
          y_d     = src_data;
          valid_d = 1'b1;
          ptr_d   = bus.SEL;
        end else begin
          ptr_d = '0;
        end
      end else begin
        y_d     = src_data;
        ch_d    = ptr_q;
        valid_d = 1'b1;
        if (dcnt_q == LastCnt) begin
          wrap_d = (ptr_q == LastCh);
          dcnt_d = '0;
          ptr_d  = (ptr_q == LastCh) ? '0 : ptr_q + SELW'(1);
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.Y      = y_q;
  assign bus.CH_OUT = ch_q;
  assign bus.VALID  = valid_q;
  assign bus.WRAP   = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Randomised and directed bench for mux_nx1_scan; a frame-position reference model feeds
// an expectation queue that a negedge monitor drains against the registered outputs.
module tb_mux_nx1_scan;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CH    = 4;
  localparam int unsigned SELW  = 3;
  localparam int unsigned DWELL = 3;
  localparam int unsigned FRAME = CH * DWELL;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [SELW-1:0]  ch;
    logic             valid;
    logic             wrap;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  mux_nx1_scan_if #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) bus ();

  mux_nx1_scan #(
    .WIDTH(WIDTH),
    .CH   (CH),
    .SELW (SELW),
    .DWELL(DWELL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: position within a scan frame, plus the last shown channel.
  int              pos  = 0;
  logic [SELW-1:0] m_ch = '0;

  function automatic exp_t model(input logic [CH*WIDTH-1:0] d, input logic [SELW-1:0] sel,
                                 input logic g, input logic m);
    exp_t e;
    int   c;
    e = '0;
    if (g) begin
      e.ch = m_ch;
    end else if (!m) begin
      e.ch = sel;
      if (int'(sel) < CH) begin
        e.y     = d[int'(sel)*WIDTH +: WIDTH];
        e.valid = 1'b1;
        pos     = int'(sel) * DWELL;
      end else begin
        pos = 0;
      end
    end else begin
      c       = pos / DWELL;
      e.ch    = SELW'(c);
      e.y     = d[c*WIDTH +: WIDTH];
      e.valid = 1'b1;
      e.wrap  = (pos == FRAME - 1);
      pos     = (pos + 1) % FRAME;
    end
    m_ch = e.ch;
    return e;
  endfunction

  // Entered just after a rising edge; applies inputs for the next edge.
  task automatic cyc(input logic [CH*WIDTH-1:0] d, input logic [SELW-1:0] sel,
                     input logic g, input logic m);
    exp_t e;
    bus.D    = d;
    bus.SEL  = sel;
    bus.Gbar = g;
    bus.MODE = m;
    e = model(d, sel, g, m);
    @(posedge CLK);
    expq.push_back(e);
    #1;
  endtask

  task automatic check_zero(input string name);
    total++;
    if (bus.Y !== '0 || bus.CH_OUT !== '0 || bus.VALID !== 1'b0 || bus.WRAP !== 1'b0) begin
      bad++;
      $display("FAIL %s: Y=%h CH_OUT=%0d VALID=%b WRAP=%b, required all zero",
               name, bus.Y, bus.CH_OUT, bus.VALID, bus.WRAP);
    end
  endtask

  // Asserts reset between edges and checks it took effect without a clock edge.
  task automatic reset_mid;
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check_zero("async_reset");
    pos  = 0;
    m_ch = '0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_zero("reset_hold");
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (bus.Y !== e.y || bus.CH_OUT !== e.ch || bus.VALID !== e.valid || bus.WRAP !== e.wrap) begin
        bad++;
        $display("FAIL outputs @%0t: got Y=%h CH_OUT=%0d VALID=%b WRAP=%b, want Y=%h CH_OUT=%0d VALID=%b WRAP=%b",
                 $time, bus.Y, bus.CH_OUT, bus.VALID, bus.WRAP, e.y, e.ch, e.valid, e.wrap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [CH*WIDTH-1:0] DPat = 16'hDCBA;

  initial begin
    logic [31:0]         r;
    logic [CH*WIDTH-1:0] d;
    logic                m;
    RST      = 1'b1;
    bus.D    = '0;
    bus.SEL  = '0;
    bus.Gbar = 1'b1;
    bus.MODE = 1'b0;
    #12;
    check_zero("reset_state");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Manual select, disable and out-of-range selects.
    cyc(DPat, 3'd2, 1'b0, 1'b0);
    cyc(DPat, 3'd3, 1'b0, 1'b0);
    cyc(DPat, 3'd0, 1'b0, 1'b0);
    cyc(DPat, 3'd1, 1'b1, 1'b0);
    cyc(DPat, 3'd4, 1'b0, 1'b0);
    cyc(DPat, 3'd7, 1'b0, 1'b0);

    // Full scan frame from reset plus wrap-around.
    reset_mid();
    for (int i = 0; i < 13; i++) cyc(DPat, 3'd0, 1'b0, 1'b1);

    // Freeze for 5 cycles after the 2nd sample of channel 1.
    reset_mid();
    for (int i = 0; i < 5; i++) cyc(DPat, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(DPat, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(DPat, 3'd0, 1'b0, 1'b1);

    // Manual to scan handoff, then back to manual mid-dwell.
    cyc(DPat, 3'd2, 1'b0, 1'b0);
    cyc(DPat, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(DPat, 3'd0, 1'b0, 1'b1);
    cyc(DPat, 3'd1, 1'b0, 1'b0);
    cyc(DPat, 3'd5, 1'b0, 1'b1);

    // Random traffic with sticky mode, occasional disables and one mid-run reset.
    m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      d = r[CH*WIDTH-1:0];
      if ($urandom_range(0, 9) == 0) m = ~m;
      cyc(d, SELW'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), m);
      if (i == 200) reset_mid();
    end

    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
